// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer controller: state encoding and BCD digit limits.
package egg_timer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int ONES_MAX     = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    // States in which the divider runs and ticks advance the prescaler.
    function automatic logic is_counting(state_e s);
        return (s == ST_RUN) || (s == ST_ALARM);
    endfunction

endpackage

// File: rtl/egg_timer_ctrl_if.sv
// Button / divider / display bundle around the egg timer controller.
// master = button, divider and display side; slave = the controller.
interface egg_timer_ctrl_if;
    import egg_timer_pkg::*;

    logic             div_clk;
    logic             btn_min;
    logic             btn_sec;
    logic             btn_start;
    logic             btn_clr;
    logic             div_en;
    logic [BCD_W-1:0] min_t;
    logic [BCD_W-1:0] min_o;
    logic [BCD_W-1:0] sec_t;
    logic [BCD_W-1:0] sec_o;
    logic [1:0]       state;
    logic             alarm;
    logic             disp_blank;

    modport master (
        output div_clk, btn_min, btn_sec, btn_start, btn_clr,
        input  div_en, min_t, min_o, sec_t, sec_o, state, alarm, disp_blank
    );

    modport slave (
        input  div_clk, btn_min, btn_sec, btn_start, btn_clr,
        output div_en, min_t, min_o, sec_t, sec_o, state, alarm, disp_blank
    );

endinterface

// File: rtl/egg_bcd_digit.sv
// One registered BCD digit with wrap-around increment/decrement.
// carry_o/borrow_o flag that the current inc/dec wraps, so digits chain combinationally.
module egg_bcd_digit
    import egg_timer_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [BCD_W-1:0] value_o,
    output logic             carry_o,
    output logic             borrow_o
);

    localparam logic [BCD_W-1:0] MAXV = BCD_W'(MAX);

    logic [BCD_W-1:0] value_q, value_d;

    assign carry_o  = inc_i && (value_q == MAXV);
    assign borrow_o = dec_i && (value_q == '0);
    assign value_o  = value_q;

    // Next digit value: clear wins over increment, increment over decrement.
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = carry_o ? '0 : value_q + 1'b1;
        end else if (dec_i) begin
            value_d = borrow_o ? MAXV : value_q - 1'b1;
        end
    end

    // Digit register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) value_q <= '0;
        else         value_q <= value_d;
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer run/pause/alarm sequencer: gates the divider, turns its output into
// one-second events, counts MM:SS down in BCD and raises the alarm at 00:00.
// Optional build macro EGG_TIMER_BLINK_EN: blink the display in PAUSE and ALARM.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int MAX_MIN       = 99,
    parameter int ALARM_SECS    = 10
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    egg_timer_ctrl_if.slave bus
);

    localparam logic [3:0]       PRESC_LAST = 4'(TICKS_PER_SEC - 1);
    localparam logic [7:0]       ALARM_LAST = 8'(ALARM_SECS - 1);
    localparam logic [BCD_W-1:0] MM_T       = BCD_W'(MAX_MIN / 10);
    localparam logic [BCD_W-1:0] MM_O       = BCD_W'(MAX_MIN % 10);

    state_e           state_q, state_d;
    logic             div_q;
    logic             tick;
    logic             sec_evt;
    logic [3:0]       presc_q, presc_d;
    logic [7:0]       alm_q, alm_d;
    logic             div_en_q, div_en_d;
    logic             alarm_q, alarm_d;

    logic             dig_clr, min_inc, sec_inc, time_dec;
    logic             min_at_max, time_nz, time_one;
    logic [BCD_W-1:0] min_t_v, min_o_v, sec_t_v, sec_o_v;
    logic             sec_o_cy, sec_o_bw, sec_t_cy, sec_t_bw;
    logic             min_o_cy, min_o_bw, min_t_cy, min_t_bw;
    logic             unused_flags;

    assign tick       = bus.div_clk & ~div_q;
    assign sec_evt    = tick && is_counting(state_q) && (presc_q == PRESC_LAST);
    assign min_at_max = (min_t_v == MM_T) && (min_o_v == MM_O);
    assign time_nz    = |{min_t_v, min_o_v, sec_t_v, sec_o_v};
    assign time_one   = ({min_t_v, min_o_v, sec_t_v} == '0) && (sec_o_v == BCD_W'(1));

    // Seconds: tens increments on ones carry and wraps 5->0, so 59 rolls to 00 without touching minutes.
    egg_bcd_digit #(.MAX(ONES_MAX)) u_sec_o (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(sec_inc), .dec_i(time_dec), .clr_i(dig_clr),
        .value_o(sec_o_v), .carry_o(sec_o_cy), .borrow_o(sec_o_bw)
    );
    egg_bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_t (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(sec_o_cy), .dec_i(sec_o_bw), .clr_i(dig_clr),
        .value_o(sec_t_v), .carry_o(sec_t_cy), .borrow_o(sec_t_bw)
    );
    // Minutes: reaching the configured ceiling clears both digits instead of incrementing.
    egg_bcd_digit #(.MAX(ONES_MAX)) u_min_o (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(min_inc && !min_at_max), .dec_i(sec_t_bw),
        .clr_i(dig_clr || (min_inc && min_at_max)),
        .value_o(min_o_v), .carry_o(min_o_cy), .borrow_o(min_o_bw)
    );
    egg_bcd_digit #(.MAX(ONES_MAX)) u_min_t (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(min_o_cy), .dec_i(min_o_bw),
        .clr_i(dig_clr || (min_inc && min_at_max)),
        .value_o(min_t_v), .carry_o(min_t_cy), .borrow_o(min_t_bw)
    );

    // The countdown never borrows below 00:00 and seconds never carry into minutes.
    assign unused_flags = ^{sec_t_cy, min_t_cy, min_t_bw};

    // Next state, digit controls, prescaler and alarm-second counter.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        alm_d    = alm_q;
        dig_clr  = 1'b0;
        min_inc  = 1'b0;
        sec_inc  = 1'b0;
        time_dec = 1'b0;

        if (tick && is_counting(state_q)) begin
            presc_d = (presc_q == PRESC_LAST) ? 4'd0 : presc_q + 4'd1;
        end

        if (bus.btn_clr) begin
            state_d = ST_IDLE;
            dig_clr = 1'b1;
            presc_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.btn_start && time_nz) begin
                        state_d = ST_RUN;
                        presc_d = 4'd0;
                    end else begin
                        min_inc = bus.btn_min;
                        sec_inc = bus.btn_sec;
                    end
                end
                ST_RUN: begin
                    if (bus.btn_start) begin
                        state_d = ST_PAUSE;
                    end else if (sec_evt) begin
                        time_dec = 1'b1;
                        if (time_one) begin
                            state_d = ST_ALARM;
                            alm_d   = 8'd0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.btn_start) state_d = ST_RUN;
                end
                ST_ALARM: begin
                    if (bus.btn_start) begin
                        state_d = ST_IDLE;
                    end else if (sec_evt) begin
                        if (alm_q == ALARM_LAST) state_d = ST_IDLE;
                        else                     alm_d   = alm_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        div_en_d = is_counting(state_d);
        alarm_d  = (state_d == ST_ALARM);
    end

    // Control registers; outputs follow the state on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            div_q    <= 1'b0;
            presc_q  <= 4'd0;
            alm_q    <= 8'd0;
            div_en_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= bus.div_clk;
            presc_q  <= presc_d;
            alm_q    <= alm_d;
            div_en_q <= div_en_d;
            alarm_q  <= alarm_d;
        end
    end

`ifdef EGG_TIMER_BLINK_EN
    logic blank_q, blank_d;

    // Blink toggles on each raw divider edge while paused or alarming, forced off otherwise.
    always_comb begin
        blank_d = blank_q;
        if ((state_d == ST_IDLE) || (state_d == ST_RUN)) begin
            blank_d = 1'b0;
        end else if (tick) begin
            blank_d = ~blank_q;
        end
    end

    // Blink register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) blank_q <= 1'b0;
        else         blank_q <= blank_d;
    end

    assign bus.disp_blank = blank_q;
`else
    assign bus.disp_blank = 1'b0;
`endif

    assign bus.div_en = div_en_q;
    assign bus.alarm  = alarm_q;
    assign bus.state  = state_q;
    assign bus.min_t  = min_t_v;
    assign bus.min_o  = min_o_v;
    assign bus.sec_t  = sec_t_v;
    assign bus.sec_o  = sec_o_v;

endmodule
